// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX forwarding selects, load-use/branch/memory-wait
// stall and flush strobes, memory-wait timeout. Optional macro: FORWARDING_EN.
module hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_reg_write,
  input  logic                      id_is_load,
  input  logic                      ex_pc_src,
  input  logic                      mem_busy,
  output logic [1:0]                fwd_a_sel,
  output logic [1:0]                fwd_b_sel,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      flush_d,
  output logic                      flush_e,
  output logic                      freeze,
  output logic                      mem_timeout
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MEM_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  typedef logic [REG_ADDR_WIDTH-1:0] reg_t;

  reg_t          ex_rd;
  logic          ex_rw;
  reg_t          mem_rd;
  logic          mem_rw;
  reg_t          wb_rd;
  logic          wb_rw;
  logic [CW-1:0] cnt;
  logic          to_q;
  logic          hz;
  logic          ld_ex;

  assign ld_ex = id_valid && !flush_e;

`ifdef FORWARDING_EN

  reg_t ex_rs1;
  reg_t ex_rs2;
  logic ex_ld;

  // Source operand registers of the instruction now in EX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_rs1 <= '0;
      ex_rs2 <= '0;
      ex_ld  <= 1'b0;
    end else if (!freeze) begin
      ex_rs1 <= ld_ex ? id_rs1 : '0;
      ex_rs2 <= ld_ex ? id_rs2 : '0;
      ex_ld  <= ld_ex && id_is_load;
    end
  end

  logic mem_a;
  logic mem_b;
  logic wb_a;
  logic wb_b;

  assign mem_a = mem_rw && mem_rd != '0 && mem_rd == ex_rs1;
  assign mem_b = mem_rw && mem_rd != '0 && mem_rd == ex_rs2;
  assign wb_a  = wb_rw && wb_rd != '0 && wb_rd == ex_rs1;
  assign wb_b  = wb_rw && wb_rd != '0 && wb_rd == ex_rs2;

  // Operand selects, MEM result has priority over WB result
  always_comb begin
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    if (mem_a)
      fwd_a_sel = 2'b10;
    else if (wb_a)
      fwd_a_sel = 2'b01;
    if (mem_b)
      fwd_b_sel = 2'b10;
    else if (wb_b)
      fwd_b_sel = 2'b01;
  end

  // Load in EX whose result the decode instruction needs
  always_comb begin
    hz = 1'b0;
    if (id_valid && ex_ld && ex_rw && ex_rd != '0)
      hz = (ex_rd == id_rs1) || (ex_rd == id_rs2);
  end

`else

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign fwd_a_sel = 2'b00;
  assign fwd_b_sel = 2'b00;

  assign ex_hit  = ex_rw && ex_rd != '0 &&
                   (ex_rd == id_rs1 || ex_rd == id_rs2);
  assign mem_hit = mem_rw && mem_rd != '0 &&
                   (mem_rd == id_rs1 || mem_rd == id_rs2);
  assign wb_hit  = wb_rw && wb_rd != '0 &&
                   (wb_rd == id_rs1 || wb_rd == id_rs2);

  // Without bypass paths, any pending producer stalls decode
  always_comb begin
    hz = id_valid && (ex_hit || mem_hit || wb_hit);
  end

`endif

  // Shadow destination pipeline, held while memory is busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_rd  <= '0;
      ex_rw  <= 1'b0;
      mem_rd <= '0;
      mem_rw <= 1'b0;
      wb_rd  <= '0;
      wb_rw  <= 1'b0;
    end else if (!freeze) begin
      ex_rd  <= ld_ex ? id_rd : '0;
      ex_rw  <= ld_ex && id_reg_write;
      mem_rd <= ex_rd;
      mem_rw <= ex_rw;
      wb_rd  <= mem_rd;
      wb_rw  <= mem_rw;
    end
  end

  // Strobes: memory wait, then branch, then data hazard
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    freeze  = 1'b0;
    priority case (1'b1)
      mem_busy: begin
        freeze  = 1'b1;
        stall_f = 1'b1;
        stall_d = 1'b1;
      end
      ex_pc_src: begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end
      hz: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
      default: ;
    endcase
  end

  // Consecutive busy-cycle counter with sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      to_q <= 1'b0;
    end else begin
      if (!mem_busy)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
      if (mem_busy && cnt == CNT_LAST)
        to_q <= 1'b1;
    end
  end

  assign mem_timeout = to_q || (mem_busy && cnt == CNT_LAST);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; expectations follow FORWARDING_EN
// when defined, otherwise the stall-only build.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] id_rd;
  logic       id_reg_write;
  logic       id_is_load;
  logic       ex_pc_src;
  logic       mem_busy;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       stall_f;
  logic       stall_d;
  logic       flush_d;
  logic       flush_e;
  logic       freeze;
  logic       mem_timeout;

  int passed = 0;
  int total  = 0;

  localparam logic [9:0] Z     = 10'b00_00_000000;
  localparam logic [9:0] STALL = 10'b00_00_110100;
  localparam logic [9:0] FLUSH = 10'b00_00_001100;
  localparam logic [9:0] FRZ   = 10'b00_00_110010;
  localparam logic [9:0] TO    = 10'b00_00_000001;
  localparam logic [9:0] A10   = 10'b10_00_000000;
  localparam logic [9:0] B01   = 10'b00_01_000000;
  localparam logic [9:0] AB01  = 10'b01_01_000000;

  logic [9:0] o;
  assign o = {fwd_a_sel, fwd_b_sel, stall_f, stall_d,
              flush_d, flush_e, freeze, mem_timeout};

  hazard_ctrl #(.REG_ADDR_WIDTH(5), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .ex_pc_src(ex_pc_src), .mem_busy(mem_busy),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .flush_e(flush_e),
    .freeze(freeze), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [9:0] exp);
    total++;
    assert (o === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, o, exp);
  endtask

  task automatic id(input logic v, input logic [4:0] a,
                    input logic [4:0] b, input logic [4:0] d,
                    input logic w, input logic l);
    id_valid     = v;
    id_rs1       = a;
    id_rs2       = b;
    id_rd        = d;
    id_reg_write = w;
    id_is_load   = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    id(0, 0, 0, 0, 0, 0);
    repeat (4) tick();
  endtask

  initial begin
    rst = 1'b1;
    ex_pc_src = 1'b0;
    mem_busy = 1'b0;
    id(0, 0, 0, 0, 0, 0);
    #2 chk("reset", Z);
    tick();
    rst = 1'b0;

    // producer then back-to-back consumer of x5
    id(1, 1, 2, 5, 1, 0);
    #1 chk("prod", Z);
    tick();
    id(1, 5, 1, 6, 1, 0);
`ifdef FORWARDING_EN
    #1 chk("d1_id", Z);
    tick();
    id(0, 0, 0, 0, 0, 0);
    #1 chk("d1_fwd", A10);
    drain();
    // distance 2 on operand B
    id(1, 1, 2, 5, 1, 0);
    tick();
    id(0, 0, 0, 0, 0, 0);
    tick();
    id(1, 1, 5, 6, 1, 0);
    tick();
    id(0, 0, 0, 0, 0, 0);
    #1 chk("d2_fwd", B01);
    drain();
    // distance 3
    id(1, 1, 2, 5, 1, 0);
    tick();
    id(0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    id(1, 5, 5, 6, 1, 0);
    tick();
    id(0, 0, 0, 0, 0, 0);
    #1 chk("d3_fwd", Z);
    drain();
    // load-use
    id(1, 1, 2, 7, 1, 1);
    tick();
    id(1, 7, 7, 8, 1, 0);
    #1 chk("lu_stall", STALL);
    tick();
    #1 chk("lu_once", Z);
    tick();
    id(0, 0, 0, 0, 0, 0);
    #1 chk("lu_fwd", AB01);
    drain();
`else
    #1 chk("raw1", STALL);
    tick();
    #1 chk("raw2", STALL);
    tick();
    #1 chk("raw3", STALL);
    tick();
    #1 chk("raw_clr", Z);
    tick();
    id(0, 0, 0, 0, 0, 0);
    #1 chk("raw_sel", Z);
    drain();
`endif

    // writes to x0 never stall or forward
    id(1, 1, 2, 0, 1, 1);
    tick();
    id(1, 0, 0, 9, 1, 0);
    #1 chk("x0_id", Z);
    tick();
    id(0, 0, 0, 0, 0, 0);
    #1 chk("x0_ex", Z);
    drain();

    // branch wins over load-use
    id(1, 1, 2, 7, 1, 1);
    tick();
    id(1, 7, 7, 8, 1, 0);
    ex_pc_src = 1'b1;
    #1 chk("br_lu", FLUSH);
    tick();
    ex_pc_src = 1'b0;
    drain();

    // memory wait defers the branch
    id(1, 1, 2, 3, 1, 0);
    ex_pc_src = 1'b1;
    mem_busy = 1'b1;
    #1 chk("br_busy1", FRZ);
    tick();
    #1 chk("br_busy2", FRZ);
    mem_busy = 1'b0;
    #1 chk("br_after", FLUSH);
    tick();
    ex_pc_src = 1'b0;
    drain();

    // freeze holds the shadow pipeline
    id(1, 1, 2, 5, 1, 0);
    tick();
    id(1, 5, 1, 6, 1, 0);
    mem_busy = 1'b1;
    #1 chk("frz", FRZ);
    repeat (2) tick();
    mem_busy = 1'b0;
`ifdef FORWARDING_EN
    #1 chk("frz_rel", Z);
    tick();
    id(0, 0, 0, 0, 0, 0);
    #1 chk("frz_fwd", A10);
`else
    #1 chk("frz_raw", STALL);
`endif
    drain();

    // 15 busy cycles: no timeout
    mem_busy = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      #1 chk("busy15", FRZ);
      tick();
    end
    mem_busy = 1'b0;
    #1 chk("busy15_end", Z);
    tick();

    // 16 busy cycles: timeout on the 16th, sticky
    mem_busy = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      #1 chk("busy16", (k == 16) ? (FRZ | TO) : FRZ);
      tick();
    end
    mem_busy = 1'b0;
    #1 chk("sticky1", TO);
    tick();
    #1 chk("sticky2", TO);

    // asynchronous reset mid-stream
    id(1, 1, 2, 5, 1, 0);
    tick();
    id(1, 5, 1, 6, 1, 0);
`ifdef FORWARDING_EN
    #1 chk("pre_rst", TO);
`else
    #1 chk("pre_rst", STALL | TO);
`endif
    #2 rst = 1'b1;
    #1 chk("async_rst", Z);
    tick();
    rst = 1'b0;
    #1 chk("post_rst_id", Z);
    tick();
    id(0, 0, 0, 0, 0, 0);
    #1 chk("post_rst_ex", Z);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
